// File: rtl/matriz_pkg.sv
// matriz_pkg: shared element width, loader FSM states and flat element indexing.
package matriz_pkg;
    localparam int ELEM_W = 8;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, HOLD, DONE} state_t;

    function automatic int flat_idx(input int row, input int col, input int size);
        return ELEM_W * (col + size * row);
    endfunction
endpackage

// File: rtl/loader_elem_counter.sv
// loader_elem_counter: row-major element index k with its row/col split and a last-element flag.
module loader_elem_counter #(
    parameter int SIZE = 5,
    localparam int N = SIZE * SIZE,
    localparam int KW = N > 1 ? $clog2(N) : 1,
    localparam int RW = SIZE > 1 ? $clog2(SIZE) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    output logic [KW-1:0] k,
    output logic [RW-1:0] row,
    output logic [RW-1:0] col,
    output logic          last
);
    logic col_wrap;

    assign last     = k == KW'(N - 1);
    assign col_wrap = col == RW'(SIZE - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k   <= '0;
            row <= '0;
            col <= '0;
        end else if (clear) begin
            k   <= '0;
            row <= '0;
            col <= '0;
        end else if (en) begin
            k   <= last ? '0 : k + 1'b1;
            col <= col_wrap ? '0 : col + 1'b1;
            row <= col_wrap ? (row == RW'(SIZE - 1) ? '0 : row + 1'b1) : row;
        end
    end
endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: streams matrices A then B into flat registers and holds them for a downstream multiplier.
// Define MATRIX_LOADER_TRANSPOSE_EN to store the B stream column-major.
module matrix_loader
    import matriz_pkg::*;
#(
    parameter int SIZE = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [ELEM_W*SIZE*SIZE-1:0]   matriz_a,
    output logic [ELEM_W*SIZE*SIZE-1:0]   matriz_b,
    output logic                          mat_valid,
    output logic                          done,
    output logic                          busy
);
    localparam int N  = SIZE * SIZE;
    localparam int KW = N > 1 ? $clog2(N) : 1;
    localparam int RW = SIZE > 1 ? $clog2(SIZE) : 1;

    state_t        state, state_nxt;
    logic [KW-1:0] k;
    logic [RW-1:0] row, col, hold_cnt;
    logic          last, xfer, hold_last;

    assign xfer      = in_valid && in_ready;
    assign hold_last = hold_cnt == RW'(SIZE - 1);

    loader_elem_counter #(.SIZE(SIZE)) u_cnt (
        .clock(clock),
        .reset(reset),
        .clear(state == IDLE),
        .en(xfer),
        .k(k),
        .row(row),
        .col(col),
        .last(last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? LOAD_A : IDLE;
            LOAD_A:  state_nxt = xfer && last ? LOAD_B : LOAD_A;
            LOAD_B:  state_nxt = xfer && last ? HOLD : LOAD_B;
            HOLD:    state_nxt = hold_last ? DONE : HOLD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == LOAD_A || state == LOAD_B;
        mat_valid = state == HOLD;
        done      = state == DONE;
        busy      = state != IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) hold_cnt <= '0;
        else hold_cnt <= state == HOLD && !hold_last ? hold_cnt + 1'b1 : '0;
    end

    // Element (r,c) of B is matched against the stream index k in the configured order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            matriz_a <= '0;
            matriz_b <= '0;
        end else if (xfer) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    if (state == LOAD_A && row == RW'(r) && col == RW'(c))
                        matriz_a[flat_idx(r, c, SIZE) +: ELEM_W] <= in_data;
`ifdef MATRIX_LOADER_TRANSPOSE_EN
                    if (state == LOAD_B && k == KW'(r + SIZE * c))
`else
                    if (state == LOAD_B && k == KW'(c + SIZE * r))
`endif
                        matriz_b[flat_idx(r, c, SIZE) +: ELEM_W] <= in_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: scoreboard bench for matrix_loader at SIZE=2 and SIZE=5.
module tb_matrix_loader;
    logic         clock = 0;
    logic         reset, start, in_valid, in_ready, mat_valid, done, busy;
    logic [7:0]   in_data;
    logic [31:0]  matriz_a, matriz_b;
    logic         start5, in_valid5, in_ready5, mat_valid5, done5, busy5;
    logic [7:0]   in_data5;
    logic [199:0] matriz_a5, matriz_b5;
    int           checks = 0, errors = 0, cyc = 0, mv2 = 0, mv5 = 0;

    typedef struct {logic [31:0] a; logic [31:0] b; int cyc;} exp_t;
    typedef struct {logic [199:0] a; logic [7:0] b0; logic [7:0] b24; int cyc;} exp5_t;
    exp_t  q2[$];
    exp5_t q5[$];

`ifdef MATRIX_LOADER_TRANSPOSE_EN
    localparam logic [31:0] EXP_B1 = 32'h08060705;
    localparam logic [31:0] EXP_B2 = 32'h0C0A0B09;
`else
    localparam logic [31:0] EXP_B1 = 32'h08070605;
    localparam logic [31:0] EXP_B2 = 32'h0C0B0A09;
`endif

    matrix_loader #(.SIZE(2)) dut (
        .clock(clock), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .matriz_a(matriz_a), .matriz_b(matriz_b),
        .mat_valid(mat_valid), .done(done), .busy(busy)
    );

    matrix_loader #(.SIZE(5)) dut5 (
        .clock(clock), .reset(reset), .start(start5), .in_data(in_data5), .in_valid(in_valid5),
        .in_ready(in_ready5), .matriz_a(matriz_a5), .matriz_b(matriz_b5),
        .mat_valid(mat_valid5), .done(done5), .busy(busy5)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset) mv2 = 0;
        else begin
            if (mat_valid) begin
                mv2++;
                chk("ready_in_hold", 200'(in_ready), 200'(0));
            end
            if (done) begin
                if (q2.size() == 0) chk("spurious_done", 200'(done), 200'(0));
                else begin
                    e = q2.pop_front();
                    chk("matriz_a", 200'(matriz_a), 200'(e.a));
                    chk("matriz_b", 200'(matriz_b), 200'(e.b));
                    chk("done_cycle", 200'(cyc), 200'(e.cyc));
                    chk("mat_valid_len", 200'(mv2), 200'(2));
                end
                mv2 = 0;
            end
        end
    end

    always @(negedge clock) begin
        exp5_t e;
        if (reset) mv5 = 0;
        else begin
            if (mat_valid5) mv5++;
            if (done5) begin
                if (q5.size() == 0) chk("spurious_done5", 200'(done5), 200'(0));
                else begin
                    e = q5.pop_front();
                    chk("s5_matriz_a", matriz_a5, e.a);
                    chk("s5_b_min", 200'(matriz_b5[7:0]), 200'(e.b0));
                    chk("s5_b_max", 200'(matriz_b5[199:192]), 200'(e.b24));
                    chk("s5_done_cycle", 200'(cyc), 200'(e.cyc));
                    chk("s5_mat_valid_len", 200'(mv5), 200'(5));
                end
                mv5 = 0;
            end
        end
    end

    task automatic wait_drain2();
        int n = 0;
        while (q2.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk("done_timeout", 200'(q2.size()), 200'(0));
        q2.delete();
    endtask

    task automatic run_load(input logic [31:0] a_s, input logic [31:0] b_s, input logic [31:0] ea,
                            input logic [31:0] eb, input bit gaps, input bit restart);
        exp_t e;
        int   n;
        e.a = ea;
        e.b = eb;
        e.cyc = cyc + 11 + (gaps ? 8 : 0);
        q2.push_back(e);
        start = 1;
        @(posedge clock); #1;
        start = 0;
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                in_valid = 0;
                @(posedge clock); #1;
            end
            if (restart && i == 5) start = 1;
            in_data  = i < 4 ? a_s[8*i +: 8] : b_s[8*(i-4) +: 8];
            in_valid = 1;
            n = 0;
            while (!in_ready && n < 20) begin
                @(posedge clock); #1;
                n++;
            end
            if (n == 20) chk("ready_timeout", 200'(in_ready), 200'(1));
            @(posedge clock); #1;
            start = 0;
            if (i == 0) chk("write_latency", 200'(matriz_a[7:0]), 200'(a_s[7:0]));
        end
        in_valid = 0;
        if (restart) begin
            start = 1;
            @(posedge clock); #1;
            start = 0;
        end
        wait_drain2();
        repeat (3) @(posedge clock);
        #1;
        chk("idle_after_done", 200'(busy), 200'(0));
    endtask

    initial begin
        exp5_t e5;
        int    n;
        reset = 1; start = 0; in_valid = 0; in_data = 0;
        start5 = 0; in_valid5 = 0; in_data5 = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_in_ready", 200'(in_ready), 200'(0));
        chk("rst_mat_valid", 200'(mat_valid), 200'(0));
        chk("rst_done", 200'(done), 200'(0));
        chk("rst_busy", 200'(busy), 200'(0));
        chk("rst_matriz_a", 200'(matriz_a), 200'(0));
        chk("rst_matriz_b", 200'(matriz_b), 200'(0));
        reset = 0;
        @(posedge clock); #1;

        run_load(32'h04030201, 32'h08070605, 32'h04030201, EXP_B1, 0, 0);
        run_load(32'h04030201, 32'h08070605, 32'h04030201, EXP_B1, 1, 0);
        run_load(32'h7F8011F0, 32'h0C0B0A09, 32'h7F8011F0, EXP_B2, 0, 1);

        start = 1;
        @(posedge clock); #1;
        start = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1;
            in_data  = 8'(i + 1);
            @(posedge clock); #1;
        end
        in_valid = 0;
        chk("partial_a", 200'(matriz_a), 200'(32'h7F030201));
        chk("partial_busy", 200'(busy), 200'(1));
        reset = 1;
        #1;
        chk("abort_matriz_a", 200'(matriz_a), 200'(0));
        chk("abort_matriz_b", 200'(matriz_b), 200'(0));
        chk("abort_busy", 200'(busy), 200'(0));
        chk("abort_in_ready", 200'(in_ready), 200'(0));
        chk("abort_done", 200'(done), 200'(0));
        @(posedge clock); #1;
        reset = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("abort_stays_idle", 200'(busy), 200'(0));
        run_load(32'h04030201, 32'h08070605, 32'h04030201, EXP_B1, 0, 0);

        for (int i = 0; i < 25; i++) e5.a[8*i +: 8] = 8'(i);
        e5.b0  = 8'h80;
        e5.b24 = 8'h7F;
        e5.cyc = cyc + 56;
        q5.push_back(e5);
        start5 = 1;
        @(posedge clock); #1;
        start5 = 0;
        for (int i = 0; i < 50; i++) begin
            in_valid5 = 1;
            in_data5  = i < 25 ? 8'(i) : i == 25 ? 8'h80 : i == 49 ? 8'h7F : 8'(i + 75);
            @(posedge clock); #1;
        end
        in_valid5 = 0;
        n = 0;
        while (q5.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        #1;
        chk("s5_done_timeout", 200'(q5.size()), 200'(0));
        repeat (5) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
